// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit common-anode seven-segment display path.
// Segment codes are active-low {dp,g,f,e,d,c,b,a} with the decimal point off.
package seg7_pkg;

  localparam int NDIG = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  localparam logic [7:0] SEG_HEX_0 = 8'hC0;
  localparam logic [7:0] SEG_HEX_1 = 8'hF9;
  localparam logic [7:0] SEG_HEX_2 = 8'hA4;
  localparam logic [7:0] SEG_HEX_3 = 8'hB0;
  localparam logic [7:0] SEG_HEX_4 = 8'h99;
  localparam logic [7:0] SEG_HEX_5 = 8'h92;
  localparam logic [7:0] SEG_HEX_6 = 8'h82;
  localparam logic [7:0] SEG_HEX_7 = 8'hF8;
  localparam logic [7:0] SEG_HEX_8 = 8'h80;
  localparam logic [7:0] SEG_HEX_9 = 8'h90;
  localparam logic [7:0] SEG_HEX_A = 8'h88;
  localparam logic [7:0] SEG_HEX_B = 8'h83;
  localparam logic [7:0] SEG_HEX_C = 8'hC6;
  localparam logic [7:0] SEG_HEX_D = 8'hA1;
  localparam logic [7:0] SEG_HEX_E = 8'h86;
  localparam logic [7:0] SEG_HEX_F = 8'h8E;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Kept standalone so other debug displays can reuse it.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    unique case (nib_i)
      4'h0: seg_o = SEG_HEX_0;
      4'h1: seg_o = SEG_HEX_1;
      4'h2: seg_o = SEG_HEX_2;
      4'h3: seg_o = SEG_HEX_3;
      4'h4: seg_o = SEG_HEX_4;
      4'h5: seg_o = SEG_HEX_5;
      4'h6: seg_o = SEG_HEX_6;
      4'h7: seg_o = SEG_HEX_7;
      4'h8: seg_o = SEG_HEX_8;
      4'h9: seg_o = SEG_HEX_9;
      4'hA: seg_o = SEG_HEX_A;
      4'hB: seg_o = SEG_HEX_B;
      4'hC: seg_o = SEG_HEX_C;
      4'hD: seg_o = SEG_HEX_D;
      4'hE: seg_o = SEG_HEX_E;
      4'hF: seg_o = SEG_HEX_F;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Captures the CPU seg7 word and scans it as 8 hex digits, swapping in new
// data only at frame boundaries so a write never tears a displayed frame.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int CNT_W    = 17
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        seg7_we,
  input  logic [31:0] cpuseg7_data,
  input  logic        lz_blank,
  output logic [7:0]  disp_an_o,
  output logic [7:0]  disp_seg_o,
  output logic [31:0] disp_data_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             live_q, live_d;
  logic [31:0]      pend_r_q, pend_r_d;
  logic             pend_v_q, pend_v_d;
  logic [31:0]      disp_r_q, disp_r_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;

  logic             tick;
  logic             fb;
  logic [4:0]       bit_base;
  logic [3:0]       nib;
  logic [7:0]       nib_seg;
  logic             blank;

  seg7_hex_decode u_hex_decode (
    .nib_i (nib),
    .seg_o (nib_seg)
  );

  always_comb begin
    tick       = (scan_cnt_q == CNT_LAST);
    fb         = tick && live_q && (idx_q == 3'd7);
    scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;

    // The first tick after reset lights digit 0 in place; later ticks advance.
    live_d = live_q | tick;
    idx_d  = idx_q;
    if (tick && live_q) idx_d = idx_q + 3'd1;

    pend_r_d = pend_r_q;
    pend_v_d = pend_v_q;
    disp_r_d = disp_r_q;
    if (fb) begin
      if (seg7_we)       disp_r_d = cpuseg7_data;
      else if (pend_v_q) disp_r_d = pend_r_q;
      pend_v_d = 1'b0;
    end else if (seg7_we) begin
      pend_r_d = cpuseg7_data;
      pend_v_d = 1'b1;
    end

    // Digit content comes from the post-edge register so a frame swap shows on digit 0.
    bit_base = {idx_d, 2'b00};
    nib      = disp_r_d[bit_base +: 4];
    blank    = lz_blank && (idx_d != 3'd0) && ((disp_r_d >> bit_base) == 32'd0);

    an_d  = an_q;
    seg_d = seg_q;
    if (tick) begin
      an_d  = blank ? AN_OFF    : ~(8'b1 << idx_d);
      seg_d = blank ? SEG_BLANK : nib_seg;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      live_q     <= 1'b0;
      pend_r_q   <= 32'd0;
      pend_v_q   <= 1'b0;
      disp_r_q   <= 32'd0;
      an_q       <= AN_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      live_q     <= live_d;
      pend_r_q   <= pend_r_d;
      pend_v_q   <= pend_v_d;
      disp_r_q   <= disp_r_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign disp_an_o   = an_q;
  assign disp_seg_o  = seg_q;
  assign disp_data_o = disp_r_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with a frame-level reference model.
module tb_seg7_scan_ctrl;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        seg7_we = 1'b0;
  logic [31:0] cpuseg7_data = 32'd0;
  logic        lz_blank = 1'b0;
  logic [7:0]  disp_an_o;
  logic [7:0]  disp_seg_o;
  logic [31:0] disp_data_o;

  seg7_scan_ctrl #(.SCAN_DIV(SD), .CNT_W(3)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .seg7_we      (seg7_we),
    .cpuseg7_data (cpuseg7_data),
    .lz_blank     (lz_blank),
    .disp_an_o    (disp_an_o),
    .disp_seg_o   (disp_seg_o),
    .disp_data_o  (disp_data_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  an;
    logic [7:0]  seg;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model: edges since release, shown word, latest pending write.
  int          cyc;
  logic [31:0] m_shown, m_pend;
  bit          m_pv;
  logic [7:0]  m_an, m_seg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    cyc = 0; m_shown = 32'd0; m_pend = 32'd0; m_pv = 1'b0;
    m_an = 8'hFF; m_seg = 8'hFF;
    sb_q.delete();
  endtask

  function automatic bit is_fb(input int c);
    int t;
    t = c / SD;
    return (c % SD == 0) && (t > 1) && ((t - 1) % 8 == 0);
  endfunction

  task automatic model_edge(input bit we, input logic [31:0] d, input bit lz);
    int c, t, dig;
    bit blank;
    logic [31:0] upper;
    logic [3:0] nib;
    logic [7:0] onehot;
    exp_t e;
    c = cyc + 1;
    cyc = c;
    if (is_fb(c)) begin
      if (we) m_shown = d;
      else if (m_pv) m_shown = m_pend;
      m_pv = 1'b0;
    end else if (we) begin
      m_pend = d;
      m_pv = 1'b1;
    end
    if (c % SD == 0) begin
      t = c / SD;
      dig = (t - 1) % 8;
      upper = m_shown >> (4 * dig);
      nib = upper[3:0];
      blank = lz && (dig != 0) && (upper == 32'd0);
      onehot = 8'h01 << dig;
      m_an  = blank ? 8'hFF : ~onehot;
      m_seg = blank ? 8'hFF : hex_tab[nib];
    end
    e.an = m_an; e.seg = m_seg; e.data = m_shown;
    sb_q.push_back(e);
  endtask

  task automatic cycle(input bit we, input logic [31:0] d, input bit lz);
    @(negedge clk);
    seg7_we = we; cpuseg7_data = d; lz_blank = lz;
    model_edge(we, d, lz);
  endtask

  task automatic idle(input int n, input bit lz);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom, lz);
  endtask

  task automatic do_reset(input bit mid);
    @(negedge clk);
    if (mid) #2;
    rstn = 1'b0;
    seg7_we = 1'b0;
    #1;
    check("rst_an", {24'd0, disp_an_o}, 32'hFF);
    check("rst_seg", {24'd0, disp_seg_o}, 32'hFF);
    check("rst_data", disp_data_o, 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    model_reset();
    rstn = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rstn) begin
      #1;
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got no expected entry at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("an", {24'd0, disp_an_o}, {24'd0, mon_e.an});
        check("seg", {24'd0, disp_seg_o}, {24'd0, mon_e.seg});
        check("data", disp_data_o, mon_e.data);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int guard;
    model_reset();
    do_reset(1'b0);
    idle(40, 1'b0);

    idle(5, 1'b0);
    cycle(1'b1, 32'h12345678, 1'b0);
    idle(80, 1'b0);

    cycle(1'b1, 32'hAABBCCDD, 1'b0);
    idle(3, 1'b0);
    cycle(1'b1, 32'h0000F00F, 1'b0);
    idle(80, 1'b0);

    guard = 0;
    while (!is_fb(cyc + 1) && guard < 40) begin
      idle(1, 1'b0);
      guard++;
    end
    check("fb_found", guard < 40, 1);
    cycle(1'b1, 32'hDEADBEEF, 1'b0);
    idle(80, 1'b0);

    cycle(1'b1, 32'h000000A0, 1'b1);
    idle(80, 1'b1);
    cycle(1'b1, 32'h00000000, 1'b1);
    idle(80, 1'b1);

    for (int i = 0; i < 800; i++) begin
      rd = $urandom;
      if ($urandom_range(1) == 1) rd = rd >> (4 * $urandom_range(7));
      cycle($urandom_range(15) == 0, rd, i[6]);
    end

    do_reset(1'b0);
    idle(10, 1'b0);
    cycle(1'b1, 32'hCAFEF00D, 1'b0);
    idle(5, 1'b0);
    do_reset(1'b1);
    idle(80, 1'b0);

    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
